// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_t     : transmitter FSM states
//   DEFAULT_CLK_HZ : default system clock frequency (iCEstick, 12 MHz)
//   DEFAULT_BAUD   : default line rate
//   calc_cpb()     : clocks per bit, integer-truncated CLK_HZ/BAUD
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLK_HZ = 12000000;
    localparam int DEFAULT_BAUD   = 115200;

    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: small synchronous FIFO held in a register array.
//   clk   : clock, posedge
//   rst   : synchronous active-low reset (empties the FIFO)
//   push  : write request; ignored while full
//   din   : write data
//   pop   : read request; ignored while empty
//   dout  : head entry (valid while empty=0)
//   full  : count == DEPTH
//   empty : count == 0
//   count : occupancy, 0..DEPTH
// Full/empty are judged on the pre-edge count, so a push into a full FIFO
// is refused even if a pop frees a slot on the same edge, and an entry
// written into an empty FIFO cannot be popped on the edge that writes it.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage needs no reset; validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//   clk         : system clock, posedge
//   rst         : synchronous active-low reset (0 = reset)
//   tx_data_rdy : one-cycle write strobe
//   tx_data     : byte sampled when tx_data_rdy=1
//   uart_tx     : registered serial line, idle high
//   tx_busy     : FSM not idle or FIFO non-empty (registered)
//   fifo_full   : FIFO holds DEPTH bytes
//   fifo_count  : FIFO occupancy
//   overflow    : sticky, set when a strobe finds the FIFO full
// The line register follows the current FSM state, so it lags the state by
// one clock: a byte strobed at edge N is popped at N+1 and the start bit
// appears after N+2. The mandatory IDLE cycle makes frames 10*CPB+1 apart.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_data_rdy,
    input  logic [7:0]              tx_data,
    output logic                    uart_tx,
    output logic                    tx_busy,
    output logic                    fifo_full,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int CPB = calc_cpb(CLK_HZ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

    tx_state_t     state_reg, state_next;
    logic [BW-1:0] baudcnt_reg, baudcnt_next;
    logic [2:0]    bitcnt_reg, bitcnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg;
    logic          busy_reg;
    logic          overflow_reg;
    logic          line_next;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          baud_end;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_data_rdy),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baudcnt_reg == BAUD_LAST);

    always_comb begin
        state_next   = state_reg;
        baudcnt_next = baudcnt_reg;
        bitcnt_next  = bitcnt_reg;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        line_next    = 1'b1;
        case (state_reg)
            IDLE: begin
                line_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    baudcnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                line_next = 1'b0;
                if (baud_end) begin
                    baudcnt_next = '0;
                    bitcnt_next  = '0;
                    state_next   = DATA;
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            DATA: begin
                line_next = shift_reg[0];
                if (baud_end) begin
                    baudcnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bitcnt_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bitcnt_next = bitcnt_reg + 1'b1;
                    end
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            STOP: begin
                line_next = 1'b1;
                if (baud_end) begin
                    baudcnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            baudcnt_reg  <= '0;
            bitcnt_reg   <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baudcnt_reg <= baudcnt_next;
            bitcnt_reg  <= bitcnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= line_next;
            // Built only from registers, so no path from tx_data_rdy.
            busy_reg    <= (state_reg != IDLE) || !fifo_empty;
            if (tx_data_rdy && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign uart_tx  = tx_reg;
    assign tx_busy  = busy_reg;
    assign overflow = overflow_reg;

endmodule
